// File: rtl/branch_target_predictor.sv
// branch_target_predictor
//   Dynamic branch predictor for the fetch stage. A direct-mapped BTB holds,
//   per entry, a valid bit, a tag, a taken target and a saturating direction
//   counter. The index is either bimodal (pc bits) or gshare (pc bits XOR a
//   global taken/not-taken history). Lookup is purely combinational on the
//   fetch PC. Training comes from the resolved branch/jump in EX. Two
//   saturating performance counters track resolved events and mispredicts.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   lookup_pc       fetch PC, looked up combinationally
//   pred_hit        valid entry with matching tag
//   pred_taken      predict taken (hit and counter MSB set)
//   pred_target     predicted next PC (stored target or lookup_pc+4)
//   upd_valid       a resolved control-flow instruction is reported this cycle
//   upd_pc          PC of the resolved instruction
//   upd_taken       actual outcome
//   upd_target      actual taken target
//   upd_mispredict  EX saw a wrong prediction (direction or target)
//   flush_all       synchronous invalidate of all entries and the history
//   stat_lookups    saturating count of upd_valid events
//   stat_mispred    saturating count of upd_valid && upd_mispredict events
module branch_target_predictor #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned TAG_W  = 8,
    parameter int unsigned CTR_W  = 2,
    parameter int unsigned GSHARE = 0,
    parameter int unsigned GHR_W  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_mispredict,
    input  logic            flush_all,
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_mispred
);

    localparam int unsigned ENTRIES = 1 << IDX_W;

    localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_MAX     = '1;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [XLEN-1:0]    tgt_mem [ENTRIES];
    logic [CTR_W-1:0]   ctr_mem [ENTRIES];
    logic [GHR_W-1:0]   ghr;

    function automatic logic [IDX_W-1:0] index_of(input logic [XLEN-1:0] pc,
                                                  input logic [GHR_W-1:0] hist);
        logic [IDX_W-1:0] idx;
        idx = pc[IDX_W+1:2];
        if (GSHARE != 0) begin
            idx = idx ^ IDX_W'(hist);
        end
        return idx;
    endfunction

    // ---------------- lookup ----------------
    logic [IDX_W-1:0] look_idx;
    logic [TAG_W-1:0] look_tag;

    assign look_idx = index_of(lookup_pc, ghr);
    assign look_tag = lookup_pc[IDX_W+2 +: TAG_W];

    always_comb begin
        pred_hit    = valid[look_idx] && (tag_mem[look_idx] == look_tag);
        pred_taken  = pred_hit && ctr_mem[look_idx][CTR_W-1];
        pred_target = pred_taken ? tgt_mem[look_idx] : lookup_pc + XLEN'(4);
    end

    // ---------------- update ----------------
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic [CTR_W-1:0] ctr_next;

    assign upd_idx = index_of(upd_pc, ghr);
    assign upd_tag = upd_pc[IDX_W+2 +: TAG_W];
    assign upd_hit = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);

    always_comb begin
        ctr_next = ctr_mem[upd_idx];
        if (upd_taken) begin
            if (ctr_mem[upd_idx] != CTR_MAX) begin
                ctr_next = ctr_mem[upd_idx] + CTR_W'(1);
            end
        end else begin
            if (ctr_mem[upd_idx] != '0) begin
                ctr_next = ctr_mem[upd_idx] - CTR_W'(1);
            end
        end
    end

    // PC bits that take no part in index or tag.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{upd_pc[1:0], upd_pc[XLEN-1:IDX_W+2+TAG_W]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid        <= '0;
            ghr          <= '0;
            stat_lookups <= '0;
            stat_mispred <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_mem[i] <= CTR_WEAK_NT;
            end
        end else if (flush_all) begin
            // Flush wins over a coincident update; stats are held.
            valid <= '0;
            ghr   <= '0;
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr_mem[upd_idx] <= ctr_next;
            end else if (upd_taken) begin
                valid[upd_idx]   <= 1'b1;
                ctr_mem[upd_idx] <= CTR_WEAK_T;
            end
            if (GSHARE != 0) begin
                ghr <= GHR_W'({ghr, upd_taken});
            end
            if (stat_lookups != '1) begin
                stat_lookups <= stat_lookups + 32'd1;
            end
            if (upd_mispredict && (stat_mispred != '1)) begin
                stat_mispred <= stat_mispred + 32'd1;
            end
        end
    end

    // Tag/target payload carries no reset: a write landing while reset is
    // asserted only touches an entry whose valid bit is being cleared.
    always_ff @(posedge clk) begin
        if (!flush_all && upd_valid && upd_taken) begin
            tgt_mem[upd_idx] <= upd_target;
            if (!upd_hit) begin
                tag_mem[upd_idx] <= upd_tag;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
module tb_branch_target_predictor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] lookup_pc, upd_pc, upd_target;
    logic        upd_valid, upd_taken, upd_mispredict, flush_all;

    logic        hit0, tk0, hit1, tk1;
    logic [31:0] tgt0, tgt1, lk0, mp0, lk1, mp1;

    branch_target_predictor #(.XLEN(32), .IDX_W(4), .TAG_W(8), .CTR_W(2), .GSHARE(0), .GHR_W(4)) dut_bim (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
        .pred_hit(hit0), .pred_taken(tk0), .pred_target(tgt0),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict), .flush_all(flush_all),
        .stat_lookups(lk0), .stat_mispred(mp0)
    );

    branch_target_predictor #(.XLEN(32), .IDX_W(4), .TAG_W(8), .CTR_W(2), .GSHARE(1), .GHR_W(4)) dut_gsh (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
        .pred_hit(hit1), .pred_taken(tk1), .pred_target(tgt1),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict), .flush_all(flush_all),
        .stat_lookups(lk1), .stat_mispred(mp1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model (instance 0 bimodal, 1 gshare) ----------------
    bit          m_valid [2][16];
    int unsigned m_tag   [2][16];
    logic [31:0] m_tgt   [2][16];
    int          m_ctr   [2][16];
    int unsigned m_ghr   [2];
    int unsigned m_lookups, m_mispred;

    function automatic int unsigned m_idx(int g, logic [31:0] pc);
        int unsigned i;
        i = (pc / 4) % 16;
        if (g == 1) i = i ^ m_ghr[g];
        return i;
    endfunction

    function automatic logic [33:0] m_pred(int g, logic [31:0] pc);
        int unsigned i;
        logic h, t;
        logic [31:0] nxt;
        i   = m_idx(g, pc);
        h   = m_valid[g][i] && (m_tag[g][i] == (pc / 64) % 256);
        t   = h && (m_ctr[g][i] >= 2);
        nxt = t ? m_tgt[g][i] : pc + 32'd4;
        return {h, t, nxt};
    endfunction

    task automatic m_reset();
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[g][i] = 1'b0;
                m_ctr[g][i]   = 1;
            end
            m_ghr[g] = 0;
        end
        m_lookups = 0;
        m_mispred = 0;
    endtask

    task automatic m_edge();
        int unsigned i;
        if (reset !== 1'b1) return;
        for (int g = 0; g < 2; g++) begin
            if (flush_all) begin
                for (int k = 0; k < 16; k++) m_valid[g][k] = 1'b0;
                m_ghr[g] = 0;
            end else if (upd_valid) begin
                i = m_idx(g, upd_pc);
                if (m_valid[g][i] && m_tag[g][i] == (upd_pc / 64) % 256) begin
                    if (upd_taken) begin
                        m_ctr[g][i] = (m_ctr[g][i] < 3) ? m_ctr[g][i] + 1 : 3;
                        m_tgt[g][i] = upd_target;
                    end else begin
                        m_ctr[g][i] = (m_ctr[g][i] > 0) ? m_ctr[g][i] - 1 : 0;
                    end
                end else if (upd_taken) begin
                    m_valid[g][i] = 1'b1;
                    m_tag[g][i]   = (upd_pc / 64) % 256;
                    m_tgt[g][i]   = upd_target;
                    m_ctr[g][i]   = 2;
                end
                if (g == 1) m_ghr[g] = (m_ghr[g] * 2 + (upd_taken ? 1 : 0)) % 16;
            end
        end
        if (!flush_all && upd_valid) begin
            m_lookups++;
            if (upd_mispredict) m_mispred++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic do_update(logic [31:0] pc, logic tk, logic [31:0] tg, logic mis);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tg; upd_mispredict = mis;
        tick();
        upd_valid = 1'b0; upd_mispredict = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_mispredict = 1'b0; flush_all = 1'b0; lookup_pc = 32'h40;
        m_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();
        lookup_pc = 32'h40; #1;
        n_cmp++;
        if ({hit0, tk0, tgt0} !== {1'b0, 1'b0, 32'h44}) begin
            n_bad++; $display("FAIL reset_lookup_bim got=%h exp=%h", {hit0, tk0, tgt0}, {1'b0, 1'b0, 32'h44});
        end
        n_cmp++;
        if ({hit1, tk1, tgt1} !== {1'b0, 1'b0, 32'h44}) begin
            n_bad++; $display("FAIL reset_lookup_gsh got=%h exp=%h", {hit1, tk1, tgt1}, {1'b0, 1'b0, 32'h44});
        end
        n_cmp++;
        if ({lk0, mp0, lk1, mp1} !== 128'd0) begin
            n_bad++; $display("FAIL reset_stats got=%h exp=0", {lk0, mp0, lk1, mp1});
        end
        lookup_pc = 32'hFFFF_FFFC; #1;
        n_cmp++;
        if (tgt0 !== 32'h0) begin
            n_bad++; $display("FAIL pc_wrap got=%h exp=00000000", tgt0);
        end
        // reset asserted while an update is pending: update must be lost
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100; upd_mispredict = 1'b1;
        lookup_pc = 32'h40;
        #1 reset = 1'b0;
        m_reset();
        @(posedge clk); #1;
        reset = 1'b1; upd_valid = 1'b0; upd_mispredict = 1'b0; #1;
        n_cmp++;
        if ({hit0, tk0, tgt0, hit1, tk1, tgt1} !== {1'b0, 1'b0, 32'h44, 1'b0, 1'b0, 32'h44}) begin
            n_bad++; $display("FAIL reset_mid_update got=%h/%h exp=0/0", {hit0, tk0, tgt0}, {hit1, tk1, tgt1});
        end
        n_cmp++;
        if ({lk0, mp0} !== 64'd0) begin
            n_bad++; $display("FAIL reset_mid_update_stats got=%h exp=0", {lk0, mp0});
        end
    endtask

    task automatic test_allocate();
        do_update(32'h40, 1'b1, 32'h100, 1'b1);
        lookup_pc = 32'h40; #1;
        n_cmp++;
        if ({hit0, tk0, tgt0} !== {1'b1, 1'b1, 32'h100}) begin
            n_bad++; $display("FAIL allocate_bim got=%h exp=%h", {hit0, tk0, tgt0}, {1'b1, 1'b1, 32'h100});
        end
        n_cmp++;
        if ({hit1, tk1, tgt1} !== m_pred(1, lookup_pc)) begin
            n_bad++; $display("FAIL allocate_gsh got=%h exp=%h", {hit1, tk1, tgt1}, m_pred(1, lookup_pc));
        end
        n_cmp++;
        if ({lk0, mp0} !== {32'd1, 32'd1}) begin
            n_bad++; $display("FAIL allocate_stats got=%h exp=1/1", {lk0, mp0});
        end
    endtask

    task automatic test_saturation();
        repeat (4) do_update(32'h40, 1'b1, 32'h100, 1'b0);
        lookup_pc = 32'h40; #1;
        n_cmp++;
        if ({hit0, tk0, tgt0} !== {1'b1, 1'b1, 32'h100}) begin
            n_bad++; $display("FAIL sat_high got=%h exp=%h", {hit0, tk0, tgt0}, {1'b1, 1'b1, 32'h100});
        end
        do_update(32'h40, 1'b0, 32'h0, 1'b0);
        n_cmp++;
        if ({hit0, tk0, tgt0} !== {1'b1, 1'b1, 32'h100}) begin
            n_bad++; $display("FAIL sat_dec1 got=%h exp=%h", {hit0, tk0, tgt0}, {1'b1, 1'b1, 32'h100});
        end
        do_update(32'h40, 1'b0, 32'h0, 1'b0);
        n_cmp++;
        if ({hit0, tk0, tgt0} !== {1'b1, 1'b0, 32'h44}) begin
            n_bad++; $display("FAIL sat_dec2 got=%h exp=%h", {hit0, tk0, tgt0}, {1'b1, 1'b0, 32'h44});
        end
        n_cmp++;
        if ({hit1, tk1, tgt1} !== m_pred(1, lookup_pc)) begin
            n_bad++; $display("FAIL sat_gsh got=%h exp=%h", {hit1, tk1, tgt1}, m_pred(1, lookup_pc));
        end
    endtask

    task automatic test_alias();
        do_update(32'h80, 1'b1, 32'h200, 1'b0);
        lookup_pc = 32'h40; #1;
        n_cmp++;
        if ({hit0, tk0, tgt0} !== {1'b0, 1'b0, 32'h44}) begin
            n_bad++; $display("FAIL alias_old got=%h exp=%h", {hit0, tk0, tgt0}, {1'b0, 1'b0, 32'h44});
        end
        lookup_pc = 32'h80; #1;
        n_cmp++;
        if ({hit0, tk0, tgt0} !== {1'b1, 1'b1, 32'h200}) begin
            n_bad++; $display("FAIL alias_new got=%h exp=%h", {hit0, tk0, tgt0}, {1'b1, 1'b1, 32'h200});
        end
        n_cmp++;
        if ({hit1, tk1, tgt1} !== m_pred(1, lookup_pc)) begin
            n_bad++; $display("FAIL alias_gsh got=%h exp=%h", {hit1, tk1, tgt1}, m_pred(1, lookup_pc));
        end
    endtask

    task automatic test_stats_ignore();
        upd_valid = 1'b0; upd_mispredict = 1'b1;
        tick();
        upd_mispredict = 1'b0;
        n_cmp++;
        if ({lk0, mp0} !== {32'd8, 32'd1}) begin
            n_bad++; $display("FAIL stats_no_valid got=%0d/%0d exp=8/1", lk0, mp0);
        end
    endtask

    task automatic test_back_to_back();
        upd_valid = 1'b1; upd_pc = 32'h240; upd_taken = 1'b1; upd_target = 32'h444; upd_mispredict = 1'b0;
        lookup_pc = 32'h240; #1;
        n_cmp++;
        if ({hit0, tk0, tgt0} !== {1'b0, 1'b0, 32'h244}) begin
            n_bad++; $display("FAIL b2b_pre got=%h exp=%h", {hit0, tk0, tgt0}, {1'b0, 1'b0, 32'h244});
        end
        tick();
        upd_valid = 1'b0; #1;
        n_cmp++;
        if ({hit0, tk0, tgt0} !== {1'b1, 1'b1, 32'h444}) begin
            n_bad++; $display("FAIL b2b_post got=%h exp=%h", {hit0, tk0, tgt0}, {1'b1, 1'b1, 32'h444});
        end
        lookup_pc = 32'h80; #1;
        n_cmp++;
        if ({hit0, tk0, tgt0} !== {1'b0, 1'b0, 32'h84}) begin
            n_bad++; $display("FAIL b2b_evict got=%h exp=%h", {hit0, tk0, tgt0}, {1'b0, 1'b0, 32'h84});
        end
    endtask

    task automatic test_flush();
        logic [31:0] pcs [4];
        pcs = '{32'h40, 32'h80, 32'h240, 32'h340};
        flush_all = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h340; upd_taken = 1'b1; upd_target = 32'h900; upd_mispredict = 1'b1;
        tick();
        flush_all = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
        foreach (pcs[k]) begin
            lookup_pc = pcs[k]; #1;
            n_cmp++;
            if ({hit0, tk0, hit1, tk1} !== 4'b0000) begin
                n_bad++; $display("FAIL flush_miss pc=%h got=%b exp=0000", pcs[k], {hit0, tk0, hit1, tk1});
            end
        end
        n_cmp++;
        if ({lk0, mp0, lk1, mp1} !== {32'd9, 32'd1, 32'd9, 32'd1}) begin
            n_bad++; $display("FAIL flush_stats got=%0d/%0d/%0d/%0d exp=9/1/9/1", lk0, mp0, lk1, mp1);
        end
    endtask

    task automatic test_gshare();
        do_update(32'h20, 1'b1, 32'h500, 1'b0);
        do_update(32'h20, 1'b1, 32'h500, 1'b0);
        do_update(32'h40, 1'b1, 32'h300, 1'b0);
        // history now 0b0111: pc 0x50 maps to idx 4^7=3 with the tag of 0x40
        lookup_pc = 32'h50; #1;
        n_cmp++;
        if ({hit1, tk1, tgt1} !== {1'b1, 1'b1, 32'h300}) begin
            n_bad++; $display("FAIL gshare_idx3 got=%h exp=%h", {hit1, tk1, tgt1}, {1'b1, 1'b1, 32'h300});
        end
        lookup_pc = 32'h5C; #1;
        n_cmp++;
        if ({hit1, tk1, tgt1} !== {1'b0, 1'b0, 32'h60}) begin
            n_bad++; $display("FAIL gshare_idx0 got=%h exp=%h", {hit1, tk1, tgt1}, {1'b0, 1'b0, 32'h60});
        end
        lookup_pc = 32'h40; #1;
        n_cmp++;
        if ({hit0, tk0, tgt0} !== m_pred(0, lookup_pc)) begin
            n_bad++; $display("FAIL gshare_bim got=%h exp=%h", {hit0, tk0, tgt0}, m_pred(0, lookup_pc));
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            upd_valid      = ($urandom_range(0, 3) != 0);
            upd_pc         = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            upd_taken      = $urandom_range(0, 2) != 0;
            upd_target     = $urandom & 32'hFFFF_FFFC;
            upd_mispredict = $urandom_range(0, 1);
            flush_all      = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 3) == 0) lookup_pc = upd_pc;
            else lookup_pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            #1;
            n_cmp++;
            if ({hit0, tk0, tgt0} !== m_pred(0, lookup_pc)) begin
                n_bad++; $display("FAIL rand_bim c=%0d pc=%h got=%h exp=%h", c, lookup_pc, {hit0, tk0, tgt0}, m_pred(0, lookup_pc));
            end
            n_cmp++;
            if ({hit1, tk1, tgt1} !== m_pred(1, lookup_pc)) begin
                n_bad++; $display("FAIL rand_gsh c=%0d pc=%h got=%h exp=%h", c, lookup_pc, {hit1, tk1, tgt1}, m_pred(1, lookup_pc));
            end
            n_cmp++;
            if ({lk0, mp0, lk1, mp1} !== {m_lookups, m_mispred, m_lookups, m_mispred}) begin
                n_bad++; $display("FAIL rand_stats c=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d", c, lk0, mp0, lk1, mp1, m_lookups, m_mispred);
            end
            tick();
        end
        upd_valid = 1'b0; flush_all = 1'b0; upd_mispredict = 1'b0;
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_saturation();
        test_alias();
        test_stats_ignore();
        test_back_to_back();
        test_flush();
        test_gshare();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
